// File: rtl/dmem_port_if.sv
// dmem_port_if: CPU/writeback request-grant bundle and single data-memory port of dmem_port_arbiter
interface dmem_port_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
);
   logic              req_0, req_1, we_0, we_1;
   logic [ADDR_W-1:0] addr_0, addr_1;
   logic [DATA_W-1:0] wdata_0, wdata_1;
   logic              wb_req;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              gnt_0, gnt_1, gnt_wb;
   logic              done_0, done_1, done_wb;
   logic [DATA_W-1:0] rdata;
   logic              err, busy;
   logic              mem_re, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rdy;
   modport master (
      input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
      input  wb_req, wb_addr, wb_data,
      output gnt_0, gnt_1, gnt_wb, done_0, done_1, done_wb, rdata, err, busy,
      output mem_re, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_rdy
   );
   modport slave (
      output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
      output wb_req, wb_addr, wb_data,
      input  gnt_0, gnt_1, gnt_wb, done_0, done_1, done_wb, rdata, err, busy,
      input  mem_re, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_rdy
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port among CPU0, CPU1 and coherence writebacks (wb first, CPUs round-robin).
// Defining DMEM_ARB_TIMEOUT_EN adds a TIMEOUT_CYC-cycle WAIT abort reported on err.
module dmem_port_arbiter #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
`ifdef DMEM_ARB_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 64
`endif
) (
   input logic clk,
   input logic rst_n,
   dmem_port_if.master bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t            state, state_nxt;
   logic [2:0]        gnt, gnt_nxt;
   logic              we_q, last_cpu, tmo;
   logic              any_req, pick_0, pick_1;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   // last_cpu = 1 means CPU1 was served last, so CPU0 wins a tie
   assign any_req = bus.wb_req | bus.req_0 | bus.req_1;
   assign pick_0  = !bus.wb_req & bus.req_0 & (!bus.req_1 | last_cpu);
   assign pick_1  = !bus.wb_req & bus.req_1 & !pick_0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state == IDLE  ? (any_req ? ISSUE : IDLE) :
                  state == ISSUE ? WAIT :
                  state == WAIT  ? ((bus.mem_rdy | tmo) ? DONE : WAIT) : IDLE;
      gnt_nxt   = state == IDLE ? {bus.wb_req, pick_1, pick_0} :
                  state == DONE ? 3'b000 : gnt;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         gnt      <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         last_cpu <= 1'b1;
      end else begin
         gnt <= gnt_nxt;
         if (state == IDLE && any_req) begin
            we_q    <= bus.wb_req | (pick_0 ? bus.we_0 : bus.we_1);
            addr_q  <= bus.wb_req ? bus.wb_addr : pick_0 ? bus.addr_0 : bus.addr_1;
            wdata_q <= bus.wb_req ? bus.wb_data : pick_0 ? bus.wdata_0 : bus.wdata_1;
         end
         if (tmo) rdata_q <= '0;
         else if (state == WAIT && bus.mem_rdy && !we_q) rdata_q <= bus.mem_rdata;
         if (state == DONE && !gnt[2]) last_cpu <= gnt[1];
      end
`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt;
   logic             err_q;
   // counter idles at zero outside WAIT, so it is clear on every WAIT entry
   assign tmo = state == WAIT && !bus.mem_rdy && cnt == CNT_W'(TIMEOUT_CYC - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         cnt   <= state == WAIT ? cnt + 1'b1 : '0;
         err_q <= tmo;
      end
   assign bus.err = err_q;
`else
   assign tmo     = 1'b0;
   assign bus.err = 1'b0;
`endif
   assign bus.gnt_0     = gnt[0];
   assign bus.gnt_1     = gnt[1];
   assign bus.gnt_wb    = gnt[2];
   assign bus.done_0    = state == DONE && gnt[0];
   assign bus.done_1    = state == DONE && gnt[1];
   assign bus.done_wb   = state == DONE && gnt[2];
   assign bus.busy      = state != IDLE;
   assign bus.mem_re    = state == ISSUE && !we_q;
   assign bus.mem_we    = state == ISSUE && we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and random transactions against a memory array and arbitration reference model
module tb_dmem_port_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_tests = 0;
   int n_fail = 0;
   bit last_cpu_m = 1'b1;
   logic [15:0] rdata_m = '0;
   logic [15:0] phys [8192];
   logic [15:0] refm [8192];
   int own;
   dmem_port_if #(.ADDR_W(13), .DATA_W(16)) bus ();
   dmem_port_arbiter #(
      .ADDR_W(13),
      .DATA_W(16)
`ifdef DMEM_ARB_TIMEOUT_EN
      , .TIMEOUT_CYC(8)
`endif
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] gnt_v();
      return {29'd0, bus.gnt_wb, bus.gnt_1, bus.gnt_0};
   endfunction
   function automatic logic [31:0] done_v();
      return {29'd0, bus.done_wb, bus.done_1, bus.done_0};
   endfunction
   // Runs one transaction from an IDLE cycle whose requests are already driven.
   // own: 0 = CPU0, 1 = CPU1, 2 = writeback (winner predicted from the priority rules)
   task automatic txn(input int lat, input bit drop, output int o);
      logic e_we;
      logic [12:0] e_addr;
      logic [15:0] e_data;
      o = bus.wb_req ? 2 : (bus.req_0 && bus.req_1) ? (last_cpu_m ? 0 : 1) : bus.req_0 ? 0 : 1;
      e_we   = o == 2 ? 1'b1 : o == 0 ? bus.we_0 : bus.we_1;
      e_addr = o == 2 ? bus.wb_addr : o == 0 ? bus.addr_0 : bus.addr_1;
      e_data = o == 2 ? bus.wb_data : o == 0 ? bus.wdata_0 : bus.wdata_1;
      tick();
      chk("issue_gnt", gnt_v(), 32'(1) << o);
      chk("issue_mem_re", bus.mem_re, !e_we);
      chk("issue_mem_we", bus.mem_we, e_we);
      chk("issue_mem_addr", bus.mem_addr, e_addr);
      if (e_we) chk("issue_mem_wdata", bus.mem_wdata, e_data);
      if (bus.mem_we) phys[bus.mem_addr] = bus.mem_wdata;
      if (e_we) refm[e_addr] = e_data;
      bus.mem_rdy = 1'($urandom_range(0, 1));
      for (int w = 0; w <= lat; w++) begin
         tick();
         chk("wait_strobes", {bus.mem_re, bus.mem_we}, 0);
         chk("wait_done", done_v(), 0);
         chk("wait_gnt", gnt_v(), 32'(1) << o);
         chk("wait_addr", bus.mem_addr, e_addr);
         bus.mem_rdy   = w == lat;
         bus.mem_rdata = w == lat ? phys[bus.mem_addr] : 16'($urandom);
      end
      if (!e_we) rdata_m = refm[e_addr];
      tick();
      chk("done_pulse", done_v(), 32'(1) << o);
      chk("done_gnt", gnt_v(), 32'(1) << o);
      chk("done_rdata", bus.rdata, rdata_m);
      chk("done_err", bus.err, 0);
      bus.mem_rdy   = 1'($urandom_range(0, 1));
      bus.mem_rdata = 16'($urandom);
      if (o != 2) last_cpu_m = o == 1;
      if (drop) begin
         if (o == 0) bus.req_0 = 1'b0;
         if (o == 1) bus.req_1 = 1'b0;
         if (o == 2) bus.wb_req = 1'b0;
      end
      tick();
      chk("idle_busy", bus.busy, 0);
      chk("idle_gnt", gnt_v(), 0);
      chk("idle_done", done_v(), 0);
      bus.mem_rdy = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < 8192; i++) begin
         phys[i] = 16'($urandom);
         refm[i] = phys[i];
      end
      {bus.req_0, bus.req_1, bus.we_0, bus.we_1, bus.wb_req, bus.mem_rdy} = '0;
      {bus.addr_0, bus.addr_1, bus.wb_addr} = '0;
      {bus.wdata_0, bus.wdata_1, bus.wb_data, bus.mem_rdata} = '0;
      tick();
      tick();
      chk("rst_gnt", gnt_v(), 0);
      chk("rst_done", done_v(), 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_strobes", {bus.mem_re, bus.mem_we}, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_err", bus.err, 0);
      rst_n = 1'b1;
      tick();
      // both CPUs held through four transactions
      bus.req_0 = 1'b1; bus.we_0 = 1'b1; bus.addr_0 = 13'h040; bus.wdata_0 = 16'h0A0A;
      bus.req_1 = 1'b1; bus.we_1 = 1'b0; bus.addr_1 = 13'h040;
      txn(0, 0, own); chk("rr_order_0", own, 0);
      txn(1, 0, own); chk("rr_order_1", own, 1);
      txn(2, 0, own); chk("rr_order_2", own, 0);
      txn(0, 0, own); chk("rr_order_3", own, 1);
      chk("rr_read_after_write", bus.rdata, 16'h0A0A);
      bus.req_0 = 1'b0; bus.req_1 = 1'b0;
      tick();
      chk("rr_no_regrant", bus.busy, 0);
      // single read with three WAIT cycles
      phys[13'h0A5] = 16'h1234; refm[13'h0A5] = 16'h1234;
      bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 13'h0A5;
      txn(3, 1, own);
      chk("read_owner", own, 0);
      chk("read_rdata", bus.rdata, 16'h1234);
      // writeback beats CPU1, then CPU0 wins the following tie
      bus.wb_req = 1'b1; bus.wb_addr = 13'h100; bus.wb_data = 16'hBEEF;
      bus.req_1 = 1'b1; bus.we_1 = 1'b0; bus.addr_1 = 13'h100;
      txn(0, 1, own); chk("wb_first", own, 2);
      txn(1, 1, own); chk("wb_then_cpu1", own, 1);
      chk("wb_data_readback", bus.rdata, 16'hBEEF);
      bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 13'h0A5;
      bus.req_1 = 1'b1; bus.we_1 = 1'b1; bus.addr_1 = 13'h0A5; bus.wdata_1 = 16'h5555;
      txn(0, 1, own); chk("tie_after_wb", own, 0);
      txn(0, 1, own); chk("tie_loser_next", own, 1);
      // reset during WAIT of a CPU1 write
      bus.req_1 = 1'b1; bus.we_1 = 1'b1; bus.addr_1 = 13'h077; bus.wdata_1 = 16'hC0DE;
      tick();
      chk("rstw_issue_we", bus.mem_we, 1);
      phys[13'h077] = 16'hC0DE; refm[13'h077] = 16'hC0DE;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("rstw_gnt", gnt_v(), 0);
      chk("rstw_done", done_v(), 0);
      chk("rstw_busy", bus.busy, 0);
      chk("rstw_mem_addr", bus.mem_addr, 0);
      chk("rstw_mem_wdata", bus.mem_wdata, 0);
      chk("rstw_rdata", bus.rdata, 0);
      rdata_m = '0;
      last_cpu_m = 1'b1;
      bus.req_1 = 1'b0;
      bus.mem_rdy = 1'b1;
      tick();
      chk("rstw_no_done", done_v(), 0);
      bus.mem_rdy = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("rstw_idle", bus.busy, 0);
      bus.req_1 = 1'b1;
      txn(2, 1, own); chk("rstw_reissue", own, 1);
      bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 13'h077;
      txn(0, 1, own);
      chk("rstw_readback", bus.rdata, 16'hC0DE);
      // random traffic over a small address window
      for (int it = 0; it < 60; it++) begin
         if (!bus.req_0 && $urandom_range(0, 1) == 1) begin
            bus.req_0 = 1'b1; bus.we_0 = 1'($urandom_range(0, 1));
            bus.addr_0 = 13'($urandom_range(8'h40, 8'h47)); bus.wdata_0 = 16'($urandom);
         end
         if (!bus.req_1 && $urandom_range(0, 1) == 1) begin
            bus.req_1 = 1'b1; bus.we_1 = 1'($urandom_range(0, 1));
            bus.addr_1 = 13'($urandom_range(8'h40, 8'h47)); bus.wdata_1 = 16'($urandom);
         end
         if (!bus.wb_req && $urandom_range(0, 3) == 0) begin
            bus.wb_req = 1'b1;
            bus.wb_addr = 13'($urandom_range(8'h40, 8'h47)); bus.wb_data = 16'($urandom);
         end
         if (!bus.req_0 && !bus.req_1 && !bus.wb_req) begin
            bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 13'($urandom_range(8'h40, 8'h47));
         end
         txn($urandom_range(0, 3), 1, own);
      end
      while (bus.req_0 || bus.req_1 || bus.wb_req) txn(0, 1, own);
      // memory never answers
      bus.req_0 = 1'b1; bus.we_0 = 1'b0; bus.addr_0 = 13'h0A5;
      bus.mem_rdy = 1'b0;
      tick();
      chk("tmo_issue_re", bus.mem_re, 1);
`ifdef DMEM_ARB_TIMEOUT_EN
      for (int w = 0; w < 8; w++) begin
         tick();
         chk("tmo_wait_busy", bus.busy, 1);
         chk("tmo_wait_done", done_v(), 0);
      end
      tick();
      chk("tmo_done", done_v(), 1);
      chk("tmo_err", bus.err, 1);
      chk("tmo_rdata", bus.rdata, 0);
      rdata_m = '0;
      last_cpu_m = 1'b0;
      bus.req_0 = 1'b0;
      tick();
      chk("tmo_err_clear", bus.err, 0);
      chk("tmo_idle", bus.busy, 0);
`else
      for (int w = 0; w < 20; w++) begin
         tick();
         chk("hang_busy", bus.busy, 1);
         chk("hang_done", done_v(), 0);
         chk("hang_err", bus.err, 0);
      end
      bus.mem_rdy = 1'b1;
      bus.mem_rdata = phys[bus.mem_addr];
      tick();
      chk("hang_done_late", done_v(), 1);
      chk("hang_rdata", bus.rdata, refm[13'h0A5]);
      bus.mem_rdy = 1'b0;
      bus.req_0 = 1'b0;
      tick();
      chk("hang_idle", bus.busy, 0);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between the two CPU cache controllers and the coherence bus writeback path. Each transaction is a single-word read or write. Requests are arbitrated with fixed priority for coherence writebacks and round-robin between CPU0 and CPU1. The block sequences each winning transaction through the memory's re/we and mem_rdy handshake, returns read data, and signals completion to the owner.

## Interface
- ADDR_W, 13, address width (full block address as carried on the coherence bus)
- DATA_W, 16, data word width
- TIMEOUT_CYC, 64, maximum WAIT cycles before abort; used only with the timeout macro

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_0 / req_1  in  1  CPU0 / CPU1 request; held high until the matching done pulse
- we_0 / we_1  in  1  1 = write, 0 = read
- addr_0 / addr_1  in  ADDR_W  request address
- wdata_0 / wdata_1  in  DATA_W  write data
- wb_req  in  1  coherence writeback request (always a write)
- wb_addr  in  ADDR_W  writeback address
- wb_data  in  DATA_W  writeback data
- gnt_0 / gnt_1 / gnt_wb  out  1  owner of the current transaction; level signal, one-hot or all zero
- done_0 / done_1 / done_wb  out  1  one-cycle completion pulse to the owner
- rdata  out  DATA_W  read data; valid while done_x is high and held until the next read completes
- err  out  1  timeout abort flag; pulses together with done_x
- busy  out  1  high in any state other than IDLE
- mem_re / mem_we  out  1  memory strobes; single-cycle
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data; valid with mem_rdy
- mem_rdy  in  1  memory completion

## Operation
- States: IDLE, ISSUE, WAIT, DONE. There is exactly one outstanding transaction at a time.
- IDLE:
  - If any request is high, select a winner, latch its address, write data and we, set its gnt, and go to ISSUE.
  - Otherwise stay in IDLE.
- Selection rules:
  - wb_req beats both CPUs.
  - Between req_0 and req_1, the CPU that was not served by the last CPU transaction wins.
  - Pointer last_cpu resets to 1, so CPU0 wins the first tie.
  - Writeback transactions do not update last_cpu.
- ISSUE: assert mem_re (read) or mem_we (write) for exactly this cycle, then go to WAIT.
- WAIT:
  - Sample mem_rdy.
  - When mem_rdy is high, capture mem_rdata into rdata (reads only) and go to DONE.
  - mem_rdy is ignored in all other states.
- DONE:
  - Pulse the owner's done, drop gnt, update last_cpu if a CPU was served, and go to IDLE.
- Held signals: mem_addr, mem_wdata and gnt are held constant from ISSUE through DONE.
- Mid-transaction request changes: a requester dropping req mid-transaction does not abort it. The transaction completes and done still pulses.
- Reset values: all outputs 0, rdata 0, state IDLE, last_cpu 1.
- Reset asserted mid-transaction: the transaction is discarded immediately with no done pulse. Requesters must reissue.

## Timing
- Grant latency: req sampled high at edge k in IDLE gives gnt_x and the mem strobe high in cycle k+1 (ISSUE). WAIT begins in cycle k+2.
- Completion: mem_rdy sampled high at edge m in WAIT gives done_x and valid rdata in cycle m+1. The block is back in IDLE at cycle m+2.
- Throughput: minimum 4 cycles per transaction with zero-wait memory (mem_rdy high on the first WAIT cycle).
- Simultaneous arrival: a new request arriving during DONE is arbitrated in the following IDLE cycle. There is no back-to-back bypass.
- Starvation bound: a CPU that holds req is served within one other-CPU transaction plus any pending writebacks.

## Configuration
- Macro: DMEM_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter clears on entry to WAIT.
  - If the counter reaches TIMEOUT_CYC with no mem_rdy, go to DONE.
  - In that DONE cycle, pulse done_x and err together and force rdata to 0.
- Undefined:
  - WAIT lasts indefinitely.
  - err is tied to 0 and no counter is built.

## Test plan
- Single read: req_0=1, we_0=0, addr_0=0x0A5, memory returns 0x1234 after 3 WAIT cycles.
  - Required: mem_re high for exactly one cycle with mem_addr=0x0A5.
  - Required: done_0 and rdata=0x1234 arrive 1 cycle after mem_rdy.
- Simultaneous CPU requests, both held: req_0 and req_1 asserted together and held through 4 transactions.
  - Required: grant order 0,1,0,1.
  - Required: done pulses alternate with no overlap.
- Writeback priority: wb_req and req_1 rise in the same cycle, wb_addr=0x100, wb_data=0xBEEF.
  - Required: gnt_wb first, with mem_we=1, mem_addr=0x100, mem_wdata=0xBEEF.
  - Required: gnt_1 follows.
  - Required: the next tie with req_0 still goes to CPU0.
- Reset mid-WAIT: rst_n pulled low during WAIT of a CPU1 write.
  - Required: all outputs 0 immediately, with no done_1.
  - Required: after release, a reissued req_1 completes normally.
- Timeout (DMEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): mem_rdy held low.
  - Required: done_0 and err both pulse in the DONE cycle after 8 WAIT cycles, with rdata=0.
  - Required: without the macro, the block stays in WAIT and busy stays 1.
